// File: rtl/maxpool_stream.sv
// Streaming sign-magnitude max-pool: reduces windows of up to WIN samples to (max, position, count).
// Optional MAXPOOL_RELU_EN clamps a negative window maximum (including -0) to +0.
module maxpool_stream #(
  parameter int Q   = 15,
  parameter int N   = 32,
  parameter int WIN = 4,
  parameter int IW  = (WIN > 1) ? $clog2(WIN) : 1,
  parameter int CW  = $clog2(WIN + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_max,
  output logic [IW-1:0] out_idx,
  output logic [CW-1:0] out_cnt
);

  // Q only describes the fixed-point format; the ordering never looks at it.
  if (Q < 0 || Q >= N) begin : g_q_out_of_range
  end
  if (WIN < 1 || WIN > 256) begin : g_win_out_of_range
  end

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  run_max_q, run_max_d;
  logic [IW-1:0] run_idx_q, run_idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  out_max_q, out_max_d;
  logic [IW-1:0] out_idx_q, out_idx_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;

  logic          accept;
  logic          transfer;
  logic          take_new;
  logic          close_win;
  logic [N-1:0]  merged_max;
  logic [IW-1:0] merged_idx;
  logic [CW-1:0] cnt_inc;
  logic [N-1:0]  closed_max;

  // Strict "a > b" under sign-magnitude ordering: +0 beats -0, negatives
  // order by smaller magnitude. Ties return 0 so the incumbent survives.
  function automatic logic sm_greater(input logic [N-1:0] a, input logic [N-1:0] b);
    if (a[N-1] != b[N-1]) begin
      return b[N-1];
    end else if (!a[N-1]) begin
      return a[N-2:0] > b[N-2:0];
    end else begin
      return a[N-2:0] < b[N-2:0];
    end
  endfunction

  assign in_ready  = (state_q == ST_ACCUM) && !reset;
  assign out_valid = (state_q == ST_HOLD);
  assign out_max   = out_max_q;
  assign out_idx   = out_idx_q;
  assign out_cnt   = out_cnt_q;

  assign accept    = in_valid && in_ready;
  assign transfer  = out_valid && out_ready;
  assign take_new  = (cnt_q == '0) || sm_greater(in_data, run_max_q);
  assign merged_max = take_new ? in_data : run_max_q;
  assign merged_idx = take_new ? cnt_q[IW-1:0] : run_idx_q;
  assign cnt_inc   = cnt_q + CW'(1);
  assign close_win = accept && (in_last || (cnt_q == CW'(WIN - 1)));

`ifdef MAXPOOL_RELU_EN
  assign closed_max = merged_max[N-1] ? '0 : merged_max;
`else
  assign closed_max = merged_max;
`endif

  always_comb begin
    state_d   = state_q;
    run_max_d = run_max_q;
    run_idx_d = run_idx_q;
    cnt_d     = cnt_q;
    out_max_d = out_max_q;
    out_idx_d = out_idx_q;
    out_cnt_d = out_cnt_q;
    case (state_q)
      ST_ACCUM: begin
        if (accept) begin
          run_max_d = merged_max;
          run_idx_d = merged_idx;
          cnt_d     = cnt_inc;
        end
        if (close_win) begin
          state_d   = ST_HOLD;
          out_max_d = closed_max;
          out_idx_d = merged_idx;
          out_cnt_d = cnt_inc;
        end
      end
      ST_HOLD: begin
        // Result registers keep their values after transfer; only the window restarts.
        if (transfer) begin
          state_d = ST_ACCUM;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_ACCUM;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_ACCUM;
      run_max_q <= '0;
      run_idx_q <= '0;
      cnt_q     <= '0;
      out_max_q <= '0;
      out_idx_q <= '0;
      out_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      run_max_q <= run_max_d;
      run_idx_q <= run_idx_d;
      cnt_q     <= cnt_d;
      out_max_q <= out_max_d;
      out_idx_q <= out_idx_d;
      out_cnt_q <= out_cnt_d;
    end
  end

endmodule

// File: tb/tb_maxpool_stream.sv
// Directed bench for maxpool_stream: WIN=4 table of windows plus handshake/reset sequences, and a WIN=1 instance.
module tb_maxpool_stream;

  logic        clk = 1'b0;
  logic        reset;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, in_last, out_valid, out_ready;
  logic [31:0] in_data, out_max;
  logic [1:0]  out_idx;
  logic [2:0]  out_cnt;

  logic        w1_in_valid, w1_in_ready, w1_in_last, w1_out_valid, w1_out_ready;
  logic [31:0] w1_in_data, w1_out_max;
  logic [0:0]  w1_out_idx;
  logic [0:0]  w1_out_cnt;

  maxpool_stream #(.Q(15), .N(32), .WIN(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_max(out_max), .out_idx(out_idx), .out_cnt(out_cnt)
  );

  maxpool_stream #(.Q(15), .N(32), .WIN(1)) dut_w1 (
    .clk(clk), .reset(reset),
    .in_valid(w1_in_valid), .in_ready(w1_in_ready), .in_data(w1_in_data), .in_last(w1_in_last),
    .out_valid(w1_out_valid), .out_ready(w1_out_ready),
    .out_max(w1_out_max), .out_idx(w1_out_idx), .out_cnt(w1_out_cnt)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0][31:0] d;
    int               n;
    logic             last;
    logic [31:0]      e_max;
    logic [1:0]       e_idx;
    logic [2:0]       e_cnt;
  } vec_t;

  vec_t vecs[9];

  function automatic logic [31:0] rexp(input logic [31:0] x);
`ifdef MAXPOOL_RELU_EN
    return x[31] ? 32'h0 : x;
`else
    return x;
`endif
  endfunction

  function automatic vec_t mk(input logic [31:0] d0, input logic [31:0] d1,
                              input logic [31:0] d2, input logic [31:0] d3,
                              input int n, input logic last, input logic [31:0] e_max,
                              input logic [1:0] e_idx, input logic [2:0] e_cnt);
    vec_t v;
    v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
    v.n = n; v.last = last; v.e_max = e_max; v.e_idx = e_idx; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  // Present one sample from a negedge, wait (bounded) for in_ready, return at the negedge after the accept.
  task automatic send_a(input logic [31:0] d, input logic last);
    int t;
    in_valid = 1'b1; in_data = d; in_last = last;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("accept_wait_ok", 32'(t < 50), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic run_win(input vec_t v, input string tag);
    out_ready = 1'b1;
    for (int k = 0; k < v.n; k++) begin
      if (k == v.n - 1) chk({tag, " pre_close_valid"}, 32'(out_valid), 32'd0);
      send_a(v.d[k], v.last && (k == v.n - 1));
    end
    chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, " in_ready_hold"}, 32'(in_ready), 32'd0);
    chk({tag, " out_max"}, out_max, v.e_max);
    chk({tag, " out_idx"}, 32'(out_idx), 32'(v.e_idx));
    chk({tag, " out_cnt"}, 32'(out_cnt), 32'(v.e_cnt));
    @(posedge clk);
    @(negedge clk);
    chk({tag, " post_xfer_valid"}, 32'(out_valid), 32'd0);
    chk({tag, " post_xfer_ready"}, 32'(in_ready), 32'd1);
    chk({tag, " post_xfer_max_held"}, out_max, v.e_max);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t rv;
    vecs[0] = mk(32'h00010000, 32'h00030000, 32'h00020000, 32'h00008000, 4, 1'b0, 32'h00030000, 2'd1, 3'd4);
    vecs[1] = mk(32'h80030000, 32'h80010000, 32'h80010000, 32'h80020000, 4, 1'b0, rexp(32'h80010000), 2'd1, 3'd4);
    vecs[2] = mk(32'h80000000, 32'h00000000, 32'h0, 32'h0, 2, 1'b1, 32'h00000000, 2'd1, 3'd2);
    vecs[3] = mk(32'h80050000, 32'h0, 32'h0, 32'h0, 1, 1'b1, rexp(32'h80050000), 2'd0, 3'd1);
    vecs[4] = mk(32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 4, 1'b0, rexp(32'h80000000), 2'd0, 3'd4);
    vecs[5] = mk(32'h80000000, 32'h00000000, 32'h00000000, 32'h80000000, 4, 1'b0, 32'h00000000, 2'd1, 3'd4);
    vecs[6] = mk(32'h80FFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 4, 1'b0, 32'h00000001, 2'd1, 3'd4);
    vecs[7] = mk(32'h00000005, 32'h00000009, 32'h00000009, 32'h0, 3, 1'b1, 32'h00000009, 2'd1, 3'd3);
    vecs[8] = mk(32'h00000002, 32'h00000001, 32'h7FFFFFFF, 32'h7FFFFFFE, 4, 1'b0, 32'h7FFFFFFF, 2'd2, 3'd4);

    reset = 1'b1;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    w1_in_valid = 1'b0; w1_in_data = '0; w1_in_last = 1'b0; w1_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset in_ready", 32'(in_ready), 32'd0);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_max", out_max, 32'd0);
    chk("reset out_idx", 32'(out_idx), 32'd0);
    chk("reset out_cnt", 32'(out_cnt), 32'd0);
    reset = 1'b0;
    #1;
    chk("after reset in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_win(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: result held 5 cycles while the next sample waits upstream.
    out_ready = 1'b0;
    send_a(32'h00040000, 1'b0);
    send_a(32'h00060000, 1'b1);
    in_valid = 1'b1; in_data = 32'h00070000; in_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp%0d in_ready", c), 32'(in_ready), 32'd0);
      chk($sformatf("bp%0d out_valid", c), 32'(out_valid), 32'd1);
      chk($sformatf("bp%0d out_max", c), out_max, 32'h00060000);
      chk($sformatf("bp%0d out_cnt", c), 32'(out_cnt), 32'd2);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp xfer out_valid", 32'(out_valid), 32'd0);
    chk("bp xfer in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    chk("bp held sample out_valid", 32'(out_valid), 32'd1);
    chk("bp held sample out_max", out_max, 32'h00070000);
    chk("bp held sample out_idx", 32'(out_idx), 32'd0);
    chk("bp held sample out_cnt", 32'(out_cnt), 32'd1);
    @(posedge clk);
    @(negedge clk);

    // Reset in the middle of a window.
    send_a(32'h00090000, 1'b0);
    send_a(32'h00000001, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst in_ready", 32'(in_ready), 32'd0);
    chk("midrst out_valid", 32'(out_valid), 32'd0);
    chk("midrst out_max", out_max, 32'd0);
    chk("midrst out_cnt", 32'(out_cnt), 32'd0);
    reset = 1'b0;
    #1;
    chk("midrst released in_ready", 32'(in_ready), 32'd1);
    chk("midrst released out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rv = mk(32'h00000001, 32'h00000002, 32'h00000003, 32'h00000002, 4, 1'b0, 32'h00000003, 2'd2, 3'd4);
    run_win(rv, "postrst");

    // Reset while a result is pending.
    out_ready = 1'b0;
    send_a(32'h00050000, 1'b1);
    chk("holdrst pre out_valid", 32'(out_valid), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("holdrst out_valid", 32'(out_valid), 32'd0);
    chk("holdrst out_cnt", 32'(out_cnt), 32'd0);
    reset = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);

    // WIN=1: every accept closes its own window.
    for (int s = 0; s < 3; s++) begin
      logic [31:0] d;
      int t;
      d = (s == 0) ? 32'h80020000 : (s == 1) ? 32'h00050000 : 32'h80000000;
      w1_in_valid = 1'b1; w1_in_data = d;
      t = 0;
      while (!w1_in_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      chk($sformatf("w1 s%0d accept_wait_ok", s), 32'(t < 50), 32'd1);
      @(posedge clk);
      @(negedge clk);
      w1_in_valid = 1'b0;
      chk($sformatf("w1 s%0d out_valid", s), 32'(w1_out_valid), 32'd1);
      chk($sformatf("w1 s%0d out_max", s), w1_out_max, rexp(d));
      chk($sformatf("w1 s%0d out_idx", s), 32'(w1_out_idx), 32'd0);
      chk($sformatf("w1 s%0d out_cnt", s), 32'(w1_out_cnt), 32'd1);
      @(posedge clk);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
